// File: rtl/surf_pkg.sv
// rtl/surf_pkg.sv - shared constants and state type for the wave surface pipeline
package surf_pkg;
    localparam int         DEPTH_LOG = 10;
    localparam int         SCREEN_W  = 1 << DEPTH_LOG;
    localparam logic [9:0] CENTER    = 10'd382;
    localparam logic [9:0] MAX_H     = 10'd767;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } wpb_state_t;
endpackage

// File: rtl/wave_ram.sv
// rtl/wave_ram.sv - simple dual-port column height RAM, read-first, BRAM style
module wave_ram #(
    parameter int AW = 10,
    parameter int DW = 10
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [0:(1<<AW)-1];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Separate read process with no reset keeps the read-first BRAM template.
    always_ff @(posedge i_clk) begin
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/wave_profile_buffer.sv
// rtl/wave_profile_buffer.sv - circular wave height buffer with clear FSM and scroll-aligned raster read
module wave_profile_buffer #(
    parameter int         DEPTH_LOG = surf_pkg::DEPTH_LOG,
    parameter logic [9:0] CENTER    = surf_pkg::CENTER,
    parameter logic [9:0] MAX_H     = surf_pkg::MAX_H
) (
    input  logic                 vclock,
    input  logic                 reset,
    input  logic                 wave_we,
    input  logic [DEPTH_LOG-1:0] wave_index,
    input  logic [9:0]           wave_data,
    input  logic [10:0]          p_offset,
    input  logic [10:0]          hcount,
    input  logic [9:0]           vcount,
    input  logic                 vsync,
    input  logic                 blank,
    output logic [9:0]           wave_prof,
    output logic [10:0]          hcount_d,
    output logic [9:0]           vcount_d,
    output logic                 prof_valid,
    output logic                 ready
);
    surf_pkg::wpb_state_t  r_state;
    logic [DEPTH_LOG-1:0]  r_clr_addr;
    logic [DEPTH_LOG-1:0]  r_offset_l;
    logic                  r_vsync_q;
    logic [10:0]           r_hcount_d1;
    logic [9:0]            r_vcount_d1;
    logic                  r_valid_d1;

    logic                  w_ram_we;
    logic [DEPTH_LOG-1:0]  w_ram_waddr;
    logic [9:0]            w_ram_wdata;
    logic [9:0]            w_clamped;
    logic [DEPTH_LOG-1:0]  w_raddr;
    logic [9:0]            w_rdata;
    logic                  w_run;
    logic                  w_unused_bits;

    assign w_run         = (r_state == surf_pkg::RUN);
    assign w_clamped     = (wave_data > MAX_H) ? MAX_H : wave_data;
    assign w_raddr       = hcount[DEPTH_LOG-1:0] + r_offset_l;
    assign w_unused_bits = ^{hcount[10:DEPTH_LOG], p_offset[10:DEPTH_LOG]};

    // The clear sequencer owns the write port; game writes during CLEAR are dropped.
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_waddr = r_clr_addr;
        w_ram_wdata = CENTER;
        if (!reset) begin
            if (w_run) begin
                w_ram_we    = wave_we;
                w_ram_waddr = wave_index;
                w_ram_wdata = w_clamped;
            end else begin
                w_ram_we    = 1'b1;
            end
        end
    end

    always_ff @(posedge vclock) begin
        if (reset) begin
            r_state    <= surf_pkg::CLEAR;
            r_clr_addr <= '0;
            ready      <= 1'b0;
        end else begin
            ready <= w_run;
            if (!w_run) begin
                r_clr_addr <= r_clr_addr + 1'b1;
                if (&r_clr_addr) begin
                    r_state <= surf_pkg::RUN;
                end
            end
        end
    end

    // Offset is only taken on the vsync falling edge so a frame scrolls as one piece.
    always_ff @(posedge vclock) begin
        if (reset) begin
            r_vsync_q  <= 1'b1;
            r_offset_l <= '0;
        end else begin
            r_vsync_q <= vsync;
            if (r_vsync_q && !vsync) begin
                r_offset_l <= p_offset[DEPTH_LOG-1:0];
            end
        end
    end

    wave_ram #(
        .AW (DEPTH_LOG),
        .DW (10)
    ) u_ram (
        .i_clk   (vclock),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge vclock) begin
        if (reset) begin
            r_hcount_d1 <= '0;
            r_vcount_d1 <= '0;
            r_valid_d1  <= 1'b0;
            hcount_d    <= '0;
            vcount_d    <= '0;
            prof_valid  <= 1'b0;
            wave_prof   <= CENTER;
        end else begin
            r_hcount_d1 <= hcount;
            r_vcount_d1 <= vcount;
            r_valid_d1  <= !blank;
            hcount_d    <= r_hcount_d1;
            vcount_d    <= r_vcount_d1;
            prof_valid  <= r_valid_d1 && w_run;
            wave_prof   <= w_run ? w_rdata : CENTER;
        end
    end
endmodule

// File: tb/tb_wave_profile_buffer.sv
// tb/tb_wave_profile_buffer.sv - scoreboard bench for wave_profile_buffer
module tb_wave_profile_buffer;
    logic        vclock = 1'b0;
    logic        reset = 1'b1;
    logic        wave_we = 1'b0;
    logic [9:0]  wave_index = '0;
    logic [9:0]  wave_data = '0;
    logic [10:0] p_offset = '0;
    logic [10:0] hcount = 11'd123;
    logic [9:0]  vcount = 10'd45;
    logic        vsync = 1'b1;
    logic        blank = 1'b0;
    logic [9:0]  wave_prof;
    logic [10:0] hcount_d;
    logic [9:0]  vcount_d;
    logic        prof_valid;
    logic        ready;

    typedef struct {
        logic [9:0]  prof;
        logic [10:0] h;
        logic [9:0]  v;
        logic        valid;
        int          due;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [9:0] exp_mem [0:1023];
    logic [9:0] m_off = '0;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;

    wave_profile_buffer dut (
        .vclock     (vclock),
        .reset      (reset),
        .wave_we    (wave_we),
        .wave_index (wave_index),
        .wave_data  (wave_data),
        .p_offset   (p_offset),
        .hcount     (hcount),
        .vcount     (vcount),
        .vsync      (vsync),
        .blank      (blank),
        .wave_prof  (wave_prof),
        .hcount_d   (hcount_d),
        .vcount_d   (vcount_d),
        .prof_valid (prof_valid),
        .ready      (ready)
    );

    always #5 vclock = ~vclock;
    always @(posedge vclock) cyc <= cyc + 1;

    always @(negedge vclock) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            tests++;
            if (wave_prof !== mon_e.prof || hcount_d !== mon_e.h ||
                vcount_d !== mon_e.v || prof_valid !== mon_e.valid) begin
                fails++;
                $display("FAIL read h=%0d: got prof=%0d hd=%0d vd=%0d pv=%0b, want prof=%0d hd=%0d vd=%0d pv=%0b",
                         mon_e.h, wave_prof, hcount_d, vcount_d, prof_valid,
                         mon_e.prof, mon_e.h, mon_e.v, mon_e.valid);
            end
        end
    end

    task automatic tick;
        @(negedge vclock);
    endtask

    task automatic model_clear;
        for (int i = 0; i < 1024; i++) exp_mem[i] = 10'd382;
        m_off = '0;
    endtask

    // Drives one raster read, optionally with a same-cycle write; expectation uses pre-write contents.
    task automatic rdwr(input logic [10:0] h, input logic [9:0] v, input logic b,
                        input logic we, input logic [9:0] idx, input logic [9:0] data);
        logic [9:0] a;
        exp_t e;
        hcount = h; vcount = v; blank = b;
        wave_we = we; wave_index = idx; wave_data = data;
        a = h[9:0] + m_off;
        e.prof = exp_mem[a]; e.h = h; e.v = v; e.valid = !b; e.due = cyc + 2;
        sb.push_back(e);
        tick();
        if (we) exp_mem[idx] = (data > 10'd767) ? 10'd767 : data;
        wave_we = 1'b0;
    endtask

    task automatic wr(input logic [9:0] idx, input logic [9:0] data);
        wave_we = 1'b1; wave_index = idx; wave_data = data;
        tick();
        exp_mem[idx] = (data > 10'd767) ? 10'd767 : data;
        wave_we = 1'b0;
    endtask

    task automatic drain;
        for (int k = 0; k < 8 && sb.size() > 0; k++) tick();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d reads still pending, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic count_clear(input string tag, input bit pulse_we);
        int cnt = 0;
        int bad = 0;
        for (int k = 0; k < 1100; k++) begin
            tick();
            wave_we = 1'b0;
            if (ready === 1'b1) break;
            cnt++;
            if (prof_valid !== 1'b0 || wave_prof !== 10'd382) bad++;
            hcount = 11'(k); vcount = 10'(k);
            if (pulse_we && cnt == 300) begin
                wave_we = 1'b1; wave_index = 10'd77; wave_data = 10'd5;
            end
        end
        tests++;
        if (cnt != 1024) begin
            fails++;
            $display("FAIL %s_len: ready low for %0d cycles, want 1024", tag, cnt);
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s_outputs: %0d cycles with prof_valid/wave_prof wrong, want 0", tag, bad);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        tests++;
        if (wave_prof !== 10'd382 || hcount_d !== 11'd0 || vcount_d !== 10'd0 ||
            prof_valid !== 1'b0 || ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_vals: prof=%0d hd=%0d vd=%0d pv=%0b rdy=%0b, want 382 0 0 0 0",
                     wave_prof, hcount_d, vcount_d, prof_valid, ready);
        end
    endtask

    task automatic test_clear;
        model_clear();
        reset = 1'b0;
        count_clear("clear", 1'b1);
        for (int i = 0; i < 1024; i++) rdwr(11'(i), 10'(i), 1'b0, 1'b0, 10'd0, 10'd0);
        drain();
    endtask

    task automatic test_basic;
        wr(10'd5, 10'd300);
        rdwr(11'd5, 10'd10, 1'b0, 1'b0, 10'd0, 10'd0);
        rdwr(11'd4, 10'd11, 1'b1, 1'b0, 10'd0, 10'd0);
        rdwr(11'd5, 10'd12, 1'b1, 1'b0, 10'd0, 10'd0);
        rdwr(11'd5, 10'd13, 1'b0, 1'b0, 10'd0, 10'd0);
        drain();
    endtask

    task automatic test_clamp;
        wr(10'd9, 10'd900);
        wr(10'd10, 10'd767);
        rdwr(11'd9, 10'd1, 1'b0, 1'b0, 10'd0, 10'd0);
        rdwr(11'd10, 10'd2, 1'b0, 1'b0, 10'd0, 10'd0);
        drain();
    endtask

    task automatic test_collision;
        wr(10'd20, 10'd200);
        rdwr(11'd20, 10'd3, 1'b0, 1'b1, 10'd20, 10'd50);
        rdwr(11'd20, 10'd4, 1'b0, 1'b0, 10'd0, 10'd0);
        rdwr(11'd77, 10'd5, 1'b0, 1'b0, 10'd0, 10'd0);
        drain();
    endtask

    task automatic test_scroll;
        wr(10'd2, 10'd111);
        p_offset = 11'd2044;
        vsync = 1'b1; tick(); tick();
        vsync = 1'b0; tick();
        m_off = 10'd1020;
        rdwr(11'd6, 10'd6, 1'b0, 1'b0, 10'd0, 10'd0);
        p_offset = 11'd5;
        tick(); tick();
        rdwr(11'd6, 10'd7, 1'b0, 1'b0, 10'd0, 10'd0);
        rdwr(11'd1030, 10'd8, 1'b0, 1'b0, 10'd0, 10'd0);
        vsync = 1'b1; tick();
        vsync = 1'b0; tick();
        m_off = 10'd5;
        rdwr(11'd1021, 10'd9, 1'b0, 1'b0, 10'd0, 10'd0);
        rdwr(11'd4, 10'd10, 1'b0, 1'b0, 10'd0, 10'd0);
        drain();
    endtask

    task automatic test_reset_mid_clear;
        int bad = 0;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        reset = 1'b0;
        for (int k = 0; k < 500; k++) begin
            tick();
            if (ready !== 1'b0 || prof_valid !== 1'b0) bad++;
        end
        reset = 1'b1;
        tick(); tick();
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL midclear_first: %0d cycles ready/prof_valid high, want 0", bad);
        end
        model_clear();
        reset = 1'b0;
        count_clear("midclear", 1'b0);
        rdwr(11'd2, 10'd20, 1'b0, 1'b0, 10'd0, 10'd0);
        rdwr(11'd9, 10'd21, 1'b0, 1'b0, 10'd0, 10'd0);
        rdwr(11'd20, 10'd22, 1'b0, 1'b0, 10'd0, 10'd0);
        drain();
    endtask

    initial begin
        test_reset();
        test_clear();
        test_basic();
        test_clamp();
        test_collision();
        test_scroll();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded 500000 time units, want completion");
        $fatal(1);
    end
endmodule

// File: doc/wave_profile_buffer.md
# wave_profile_buffer

Circular column buffer holding the wave surface height for every horizontal position. It sits directly upstream of `display`. Game logic writes one column height at a time. The raster side reads the buffer at the current `hcount` plus a per-frame scroll offset and presents `wave_prof` together with delayed `hcount`/`vcount`, all aligned so that `display` compares `vcount` against the matching column height. On reset, an internal state machine fills the whole buffer with the screen centre.

## Interface
- `DEPTH_LOG`, default 10: log2 of column count; buffer holds 1024 heights.
- `CENTER`, default 382: fill value written during clear.
- `MAX_H`, default 767: largest storable height; writes above it are clamped.

Ports:
- `vclock`  in  1  65 MHz pixel clock.
- `reset`  in  1  synchronous, active-high.
- `wave_we`  in  1  write enable, one column per cycle.
- `wave_index`  in  10  column to write.
- `wave_data`  in  10  height to write, in vcount units.
- `p_offset`  in  11  scroll offset; sampled once per frame.
- `hcount`  in  11  raster column.
- `vcount`  in  10  raster line.
- `vsync`  in  1  active low.
- `blank`  in  1  raster blanking.
- `wave_prof`  out  10  height for `hcount_d`.
- `hcount_d`  out  11  `hcount` delayed 2 cycles.
- `vcount_d`  out  10  `vcount` delayed 2 cycles.
- `prof_valid`  out  1  `!blank` delayed 2 cycles, forced 0 while clearing.
- `ready`  out  1  high once the clear has finished.

## Operation
- **State machine.** Two states, CLEAR and RUN.
  - Reset enters CLEAR with `clr_addr=0`.
  - CLEAR writes CENTER to `clr_addr` each cycle, then increments `clr_addr`.
  - After writing address 1023, the machine moves to RUN and `ready` goes to 1 on the next cycle.
  - Reset asserted mid-clear restarts the clear at address 0.
- **Writes in CLEAR.** `wave_we` is ignored and the write is dropped, not queued.
- **Writes in RUN.** When `wave_we=1`, the buffer stores `min(wave_data, MAX_H)` at `wave_index`.
- **Offset latch.**
  - `vsync` is registered to form `vsync_q`.
  - `vsync_q=1 && vsync=0` is a frame start; on that cycle `offset_l <= p_offset[9:0]`.
  - `p_offset` changes at any other time have no effect. `p_offset[10]` is ignored; the offset wraps modulo 1024.
- **Read address.** `raddr = (hcount[9:0] + offset_l) mod 1024`, using a 10-bit wrapping add.
- **Read data.**
  - RUN: `wave_prof` is the stored height.
  - CLEAR: `wave_prof` is forced to CENTER regardless of buffer contents.
- **Collision.** A write and a read to the same address in the same cycle return the old data (read-first).
- **Blanking.** Reads continue during blanking; only `prof_valid` reflects `blank`.

## Timing
- **Read latency: 2 cycles.**
  - Cycle 0: `raddr` is registered.
  - Cycle 1: synchronous RAM read.
  - Cycle 2: output register.
  - `hcount_d`, `vcount_d` and `prof_valid` pass through a matching 2-stage delay.
- **Write latency.** A write at cycle N is visible to a read address registered at cycle N+1 or later.
- **Offset timing.** The new `offset_l` applies to the address registered on the cycle after the frame-start edge.
- **Clear duration.** Exactly 1024 cycles after reset deasserts. `ready` rises on cycle 1025.
- **Reset values.**
  - `wave_prof=CENTER`, `hcount_d=0`, `vcount_d=0`, `prof_valid=0`, `ready=0`.
  - `offset_l=0`, `vsync_q=1`, both delay stages cleared.

## Structure
- **Shared package** `surf_pkg`:
  - constants `DEPTH_LOG`, `CENTER=382`, `MAX_H=767`, `SCREEN_W=1024`;
  - the state type `wpb_state_t` {CLEAR, RUN}.
- **Sub-module** `wave_ram`:
  - simple dual-port, 1024×10;
  - one synchronous write port and one synchronous read port, read-first;
  - written so it infers as BRAM.
- **Top level** holds the clear FSM, clamp, offset latch, address adder and delay pipeline.

## Test plan
- **Clear.** Assert reset for 4 cycles, then release → `ready=0` for exactly 1024 cycles, then 1. Reading all 1024 columns returns 382.
- **Basic write/read.** In RUN, write `wave_index=5`, `wave_data=300`; `offset_l=0`. Drive `hcount=5` → `wave_prof=300` and `hcount_d=5` exactly 2 cycles later.
- **Scroll wrap.**
  - `p_offset=1020` sampled on a vsync falling edge; column 2 holds 111.
  - Drive `hcount=6` → `wave_prof=111`, since (6+1020) mod 1024 = 2.
  - A `p_offset` change mid-frame leaves the result unchanged until the next vsync edge.
- **Clamp.** Write `wave_data=900` to column 9 → that column reads back 767.
- **Collision and ignored writes.**
  - Same-cycle write of 50 over old value 200 at the address being read → read returns 200, and the next read returns 50.
  - `wave_we` pulsed during CLEAR → that column still reads 382 after `ready`.
- **Reset mid-clear.** Assert reset at clear cycle 500 → `ready` stays 0 until 1024 cycles after the second release. `prof_valid` stays 0 throughout.
